// File: rtl/usb_device_responder.sv
// Device-side USB transaction responder: answers OUT/IN tokens for one endpoint using 64-bit OUT and IN mailboxes.
// Optional macro NAK_ON_FULL_EN: NAK an OUT DATA0 (and keep out_data) while out_valid is still set.
package usb_device_responder_pkg;
  typedef struct packed {
    logic [7:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
  } pkt_t;

  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
endpackage

module usb_device_responder
  import usb_device_responder_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'd5,
  parameter logic [3:0]  DEV_ENDP    = 4'd4,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst_L,
  input  pkt_t        pkt_in,
  input  logic        pkt_rcvd,
  input  logic        pkt_ok,
  output logic        ack,
  output pkt_t        pkt_out,
  output logic        pkt_avail,
  input  logic        pkt_sent,
  output logic [63:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [63:0] in_data,
  input  logic        in_load,
  output logic        in_busy,
  output logic        timeout_err
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_SEND_HS, S_SEND_DATA, S_WAIT_HS
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ack_q, rel_q, pkt_avail_q, timeout_q, out_valid_q, in_busy_q;
  pkt_t             pkt_out_q;
  logic [63:0]      out_data_q, in_mbox_q;

  logic take, good, ours, tmo;

  // A packet is taken only outside the ack cycle and the decoder-release cycle after it.
  assign take = pkt_rcvd && !ack_q && !rel_q;
  assign good = take && pkt_ok;
  assign ours = (pkt_in.addr == DEV_ADDR) && (pkt_in.endp == DEV_ENDP);
  assign tmo  = (cnt_q == CNT_W'(TIMEOUT_CYC));

  function automatic pkt_t hs_pkt(input logic [7:0] pid);
    pkt_t p;
    p     = '0;
    p.pid = pid;
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ack_q       <= 1'b0;
      rel_q       <= 1'b0;
      pkt_avail_q <= 1'b0;
      timeout_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_busy_q   <= 1'b0;
      pkt_out_q   <= '0;
      out_data_q  <= '0;
      in_mbox_q   <= '0;
    end else begin
      ack_q       <= take;
      rel_q       <= ack_q;
      pkt_avail_q <= 1'b0;
      timeout_q   <= 1'b0;
      if (!tmo) cnt_q <= cnt_q + CNT_W'(1);
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (in_load && !in_busy_q) begin
        in_mbox_q <= in_data;
        in_busy_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (good && ours) begin
            if (pkt_in.pid == PID_OUT) begin
              state_q <= S_WAIT_DATA;
              cnt_q   <= '0;
            end else if (pkt_in.pid == PID_IN) begin
              pkt_avail_q <= 1'b1;
              if (in_busy_q) begin
                state_q   <= S_SEND_DATA;
                pkt_out_q <= {PID_DATA0, 7'd0, 4'd0, in_mbox_q};
              end else begin
                state_q   <= S_SEND_HS;
                pkt_out_q <= hs_pkt(PID_NAK);
              end
            end
          end
        end
        S_WAIT_DATA: begin
          if (good) begin
            if (pkt_in.pid == PID_DATA0) begin
              state_q     <= S_SEND_HS;
              pkt_avail_q <= 1'b1;
`ifdef NAK_ON_FULL_EN
              if (out_valid_q) begin
                pkt_out_q <= hs_pkt(PID_NAK);
              end else begin
                out_data_q  <= pkt_in.data;
                out_valid_q <= 1'b1;
                pkt_out_q   <= hs_pkt(PID_ACK);
              end
`else
              out_data_q  <= pkt_in.data;
              out_valid_q <= 1'b1;
              pkt_out_q   <= hs_pkt(PID_ACK);
`endif
            end else begin
              state_q <= S_IDLE;
            end
          end else if (tmo) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        S_SEND_HS: begin
          if (pkt_sent) state_q <= S_IDLE;
        end
        S_SEND_DATA: begin
          if (pkt_sent) begin
            state_q <= S_WAIT_HS;
            cnt_q   <= '0;
          end
        end
        S_WAIT_HS: begin
          // Anything but a good ACK leaves the IN mailbox armed for the host's retry.
          if (good) begin
            if (pkt_in.pid == PID_ACK) in_busy_q <= 1'b0;
            state_q <= S_IDLE;
          end else if (tmo) begin
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack         = ack_q;
  assign pkt_out     = pkt_out_q;
  assign pkt_avail   = pkt_avail_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign in_busy     = in_busy_q;
  assign timeout_err = timeout_q;
endmodule
